text_ram_scheduler: RTL
=======================

// Module: text_ram_scheduler
// PURPOSE
//  Owns port B of the 4096x32 text character RAM and arbitrates access to it.
//  Serves three requesters: single-word host writes, a clear-screen engine and
//  a scroll-up-one-row engine.
//  Sits between the host bus / console logic and the RAM port B pins
//  (addr_b/data_b/we_b/q_b); the vga_controller keeps port A.
// PARAMETERS
//  COLS    80  text columns per row
//  ROWS    30  text rows; CELLS = COLS*ROWS = 2400
//  ADDR_W  12  RAM address width
//  DATA_W  32  RAM word width (one character cell)
// PORTS
//  clk          in   1       50 MHz system clock; single clock domain
//  rst          in   1       synchronous, active-high reset
//  host_valid   in   1       host write request
//  host_ready   out  1       host write accepted when valid&ready
//  host_addr    in   ADDR_W  host write cell address
//  host_data    in   DATA_W  host write data
//  cmd_clear    in   1       1-cycle pulse: fill all CELLS with fill_word
//  cmd_scroll   in   1       1-cycle pulse: move rows up by one, fill last row
//  fill_word    in   DATA_W  fill value, sampled when a command is accepted
//  busy         out  1       clear/scroll in progress
//  done         out  1       1-cycle pulse after a command's last RAM write
//  ram_addr     out  ADDR_W  to RAM addr_b
//  ram_wdata    out  DATA_W  to RAM data_b
//  ram_we       out  1       to RAM we_b
//  ram_rdata    in   DATA_W  from RAM q_b; valid the cycle after a read is presented
// BEHAVIOUR
//  - All outputs registered.
//  - Reset values: ram_we=0, ram_addr=0, ram_wdata=0, busy=0, done=0, state=IDLE.
//  - host_ready=1 only in IDLE with cmd_clear=cmd_scroll=0 this cycle (combinational).
//  - States: IDLE, HOST_WR, CLEAR, SCR_RD, SCR_WR, SCR_FILL.
//  - IDLE:
//    - cmd_clear -> CLEAR; else cmd_scroll -> SCR_RD.
//    - Both in the same cycle: clear wins, scroll dropped.
//    - Else host_valid -> HOST_WR.
//  - Commands while busy are ignored (not queued).
//  - HOST_WR (1 cycle): ram_we=1, host addr/data; accept at cycle t -> write at t+1.
//    - host_addr >= CELLS: accepted but ram_we stays 0.
//  - CLEAR: one write per cycle to addresses 0..CELLS-1 with latched fill.
//    - Accept t -> writes t+1..t+CELLS.
//  - Scroll copy loop, i = 0..CELLS-COLS-1:
//    - SCR_RD: ram_addr=i+COLS, ram_we=0.
//    - SCR_WR: ram_addr=i, ram_wdata=ram_rdata, ram_we=1.
//    - 2 cycles per cell.
//  - SCR_FILL: addresses CELLS-COLS..CELLS-1 written with fill, one per cycle.
//    - Scroll total: 2*(CELLS-COLS)+COLS = 4720 cycles.
//  - busy=1 for every CLEAR/SCR_* cycle.
//  - done=1 the cycle after the final write; state returns to IDLE that same cycle.
//  - Cell counter: ADDR_W bits.
//    - Terminal compare is exact (== CELLS-1 or == CELLS-COLS-1).
//    - Never wraps past CELLS.
//  - rst mid-operation: next cycle ram_we=0, busy=0, done=0, IDLE.
//    - Partially written content remains; no done pulse.
//  - ram_we never asserted in IDLE or SCR_RD.
// STRUCTURE
//  - Package vga_text_pkg: COLS, ROWS, CELLS, ADDR_W, DATA_W, state encoding localparams.
//    - Shared with vga_controller.
//  - No sub-module; cell counter and FSM inline.
// TESTING
//  1. Assert rst 2 cycles -> all outputs 0, host_ready=1 after release.
//  2. host write addr 0x005 data 0xDEADBEEF -> exactly one cycle ram_we=1,
//     ram_addr=0x005, ram_wdata=0xDEADBEEF, at t+1.
//  3. cmd_clear, fill 0x00000020 -> 2400 consecutive writes to 0..2399,
//     busy high 2400 cycles, done at t+2401, host_ready=0 throughout.
//  4. RAM model preloaded mem[a]=a; cmd_scroll, fill 0x20 -> mem[i]=i+80 for i<2320,
//     mem[2320..2399]=0x20, mem[2400..4095] unchanged, done at t+4721.
//  5. cmd_clear & cmd_scroll same cycle -> clear only.
//     cmd_scroll during clear -> ignored.
//     host_addr=2400 -> accepted, no ram_we.
//  6. rst during clear at cell 100 -> ram_we=0, busy=0 next cycle, no done,
//     cells 100..2399 untouched; new host write then proceeds normally.

Source files
------------

// File: rtl/vga_text_pkg.sv
// Shared text-mode geometry and RAM port-B scheduler state encoding.
// Used by text_ram_scheduler and vga_controller.
package vga_text_pkg;

    localparam int COLS   = 80;
    localparam int ROWS   = 30;
    localparam int CELLS  = COLS * ROWS;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] LAST_CELL  = ADDR_W'(CELLS - 1);
    localparam logic [ADDR_W-1:0] COPY_LAST  = ADDR_W'(CELLS - COLS - 1);
    localparam logic [ADDR_W-1:0] FILL_START = ADDR_W'(CELLS - COLS);
    localparam logic [ADDR_W-1:0] COLS_A     = ADDR_W'(COLS);

    typedef enum logic [2:0] {
        IDLE,
        HOST_WR,
        CLEAR,
        SCR_RD,
        SCR_WR,
        SCR_FILL
    } state_t;

endpackage

// File: rtl/text_ram_scheduler_if.sv
// Host write handshake plus text RAM port-B pins.
// master = host/RAM side, slave = scheduler.
interface text_ram_scheduler_if;
    import vga_text_pkg::*;

    logic              host_valid;
    logic              host_ready;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_data;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;

    modport master (
        output host_valid, host_addr, host_data, ram_rdata,
        input  host_ready, ram_addr, ram_wdata, ram_we
    );

    modport slave (
        input  host_valid, host_addr, host_data, ram_rdata,
        output host_ready, ram_addr, ram_wdata, ram_we
    );

endinterface

// File: rtl/text_ram_scheduler.sv
// Arbitrates text RAM port B between host writes, clear and scroll.
// FSM and cell counter inline; RAM controls registered from next state.
module text_ram_scheduler
    import vga_text_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    text_ram_scheduler_if.slave bus,
    input  logic              cmd_clear,
    input  logic              cmd_scroll,
    input  logic [DATA_W-1:0] fill_word,
    output logic              busy,
    output logic              done
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] fill_q, fill_d;
    logic              we_q, we_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    assign bus.host_ready = (state_q == IDLE) && !cmd_clear && !cmd_scroll;
    assign bus.ram_addr   = addr_q;
    assign bus.ram_we     = we_q;
    // Copy data arrives the cycle after the read, so it is forwarded
    // straight from q_b to keep the copy loop at two cycles per cell.
    assign bus.ram_wdata  = (state_q == SCR_WR) ? bus.ram_rdata : wdata_q;
    assign busy           = busy_q;
    assign done           = done_q;

    // Next state plus the RAM controls to present in that state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        fill_d  = fill_q;
        we_d    = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_clear) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                    addr_d  = '0;
                    wdata_d = fill_word;
                    fill_d  = fill_word;
                    we_d    = 1'b1;
                    busy_d  = 1'b1;
                end else if (cmd_scroll) begin
                    state_d = SCR_RD;
                    cnt_d   = '0;
                    addr_d  = COLS_A;
                    fill_d  = fill_word;
                    busy_d  = 1'b1;
                end else if (bus.host_valid) begin
                    state_d = HOST_WR;
                    addr_d  = bus.host_addr;
                    wdata_d = bus.host_data;
                    we_d    = (bus.host_addr <= LAST_CELL);
                end
            end
            HOST_WR: state_d = IDLE;
            CLEAR, SCR_FILL: begin
                if (cnt_q == LAST_CELL) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                    addr_d = cnt_q + 1'b1;
                    we_d   = 1'b1;
                    busy_d = 1'b1;
                end
            end
            SCR_RD: begin
                state_d = SCR_WR;
                addr_d  = cnt_q;
                we_d    = 1'b1;
                busy_d  = 1'b1;
            end
            SCR_WR: begin
                busy_d = 1'b1;
                if (cnt_q == COPY_LAST) begin
                    state_d = SCR_FILL;
                    cnt_d   = FILL_START;
                    addr_d  = FILL_START;
                    wdata_d = fill_q;
                    we_d    = 1'b1;
                end else begin
                    state_d = SCR_RD;
                    cnt_d   = cnt_q + 1'b1;
                    addr_d  = cnt_q + 1'b1 + COLS_A;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counter and registered RAM/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            fill_q  <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            fill_q  <= fill_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

endmodule
